// File: rtl/decoder_rr_arb_if.sv
// Request/grant bundle between the requesters and the decoder round-robin arbiter.
// The master side drives requests; the slave side (the arbiter) drives the select and grant.
interface decoder_rr_arb_if;
  logic [7:0] req;
  logic [2:0] sel;
  logic [7:0] grant;
  logic       grant_vld;
  logic       grant_chg;

  modport master (output req, input sel, grant, grant_vld, grant_chg);
  modport slave  (input req, output sel, grant, grant_vld, grant_chg);
endinterface

// File: rtl/decoder_rr_arb.sv
// Round-robin arbiter that schedules eight requesters onto the 3-to-8 decoder select.
// Optional hold-time preemption is enabled by defining HOLD_LIMIT_EN.
module decoder_rr_arb #(
    parameter int MAX_HOLD = 16
) (
    input logic              sys_clk,
    input logic              sys_rst,
    decoder_rr_arb_if.slave  bus
);

`ifdef HOLD_LIMIT_EN
    localparam bit LIMIT_EN = 1'b1;
`else
    localparam bit LIMIT_EN = 1'b0;
`endif

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t     state;
    logic [2:0] ptr;
    logic [7:0] hold_cnt;

    logic [7:0] others;
    logic       owner_req;
    logic       preempt;
    logic [2:0] next_ptr;
    logic [2:0] first_idx;
    logic [2:0] next_idx;

    // First set bit of r scanning start, start+1, ... modulo 8; the descending
    // loop lets the smallest offset win.
    function automatic logic [2:0] pick(input logic [7:0] r, input logic [2:0] start);
        logic [2:0] idx;
        pick = start;
        for (int i = 7; i >= 0; i--) begin
            idx = start + 3'(i);
            if (r[idx]) pick = idx;
        end
    endfunction

    assign others    = bus.req & ~(8'h01 << bus.sel);
    assign owner_req = bus.req[bus.sel];
    assign next_ptr  = bus.sel + 3'd1;
    assign first_idx = pick(bus.req, ptr);
    assign next_idx  = pick(others, next_ptr);
    assign preempt   = LIMIT_EN && owner_req && (hold_cnt == HOLD_LAST) && (|others);

    // NOTE: reset is asynchronous so every output clears the moment sys_rst rises,
    // and all state is updated with non-blocking assignments so the edge sees old values.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state         <= IDLE;
            ptr           <= 3'd0;
            hold_cnt      <= 8'd0;
            bus.sel       <= 3'd0;
            bus.grant     <= 8'h00;
            bus.grant_vld <= 1'b0;
            bus.grant_chg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|bus.req) begin
                        state         <= GRANT;
                        bus.sel       <= first_idx;
                        bus.grant     <= 8'h01 << first_idx;
                        bus.grant_vld <= 1'b1;
                        bus.grant_chg <= 1'b1;
                        hold_cnt      <= 8'd0;
                    end else begin
                        bus.grant_chg <= 1'b0;
                    end
                end
                GRANT: begin
                    if (!owner_req || preempt) begin
                        ptr <= next_ptr;
                        if (|others) begin
                            // Direct handover: grant_vld stays high, no idle gap.
                            bus.sel       <= next_idx;
                            bus.grant     <= 8'h01 << next_idx;
                            bus.grant_chg <= 1'b1;
                            hold_cnt      <= 8'd0;
                        end else begin
                            state         <= IDLE;
                            bus.sel       <= 3'd0;
                            bus.grant     <= 8'h00;
                            bus.grant_vld <= 1'b0;
                            bus.grant_chg <= 1'b0;
                            hold_cnt      <= 8'd0;
                        end
                    end else begin
                        bus.grant_chg <= 1'b0;
                        if (hold_cnt != 8'hFF) hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_decoder_rr_arb.sv
// Directed self-checking bench for decoder_rr_arb; expectations are hand-computed.
// Builds with or without HOLD_LIMIT_EN (MAX_HOLD fixed at 4 here).
module tb_decoder_rr_arb;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    decoder_rr_arb_if bus ();

    decoder_rr_arb #(.MAX_HOLD(4)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus.slave)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [2:0] e_sel, input logic [7:0] e_grant,
                             input logic e_vld, input logic e_chg);
        check({tag, ".sel"},       {5'd0, bus.sel},       {5'd0, e_sel});
        check({tag, ".grant"},     bus.grant,             e_grant);
        check({tag, ".grant_vld"}, {7'd0, bus.grant_vld}, {7'd0, e_vld});
        check({tag, ".grant_chg"}, {7'd0, bus.grant_chg}, {7'd0, e_chg});
    endtask

    initial begin
        logic [7:0] e_grant;
        logic [2:0] e_sel;
        logic       e_chg;

        // Reset held with every requester active: outputs stay clear.
        bus.req = 8'hFF;
        #1;
        check_all("rst0", 3'd0, 8'h00, 1'b0, 1'b0);
        tick();
        check_all("rst1", 3'd0, 8'h00, 1'b0, 1'b0);
        tick();
        check_all("rst2", 3'd0, 8'h00, 1'b0, 1'b0);

        // Release reset: first edge grants requester 0 (ptr = 0).
        sys_rst = 1'b0;
        tick();
        check_all("post_rst", 3'd0, 8'h01, 1'b1, 1'b1);
        tick();
        check_all("post_rst_hold", 3'd0, 8'h01, 1'b1, 1'b0);
        bus.req = 8'h00;
        tick();
        check_all("post_rst_idle", 3'd0, 8'h00, 1'b0, 1'b0);   // ptr = 1

        // Single requester 5 for three cycles.
        bus.req = 8'h20;
        tick();
        check_all("single_c1", 3'd5, 8'h20, 1'b1, 1'b1);
        tick();
        check_all("single_c2", 3'd5, 8'h20, 1'b1, 1'b0);
        tick();
        check_all("single_c3", 3'd5, 8'h20, 1'b1, 1'b0);
        bus.req = 8'h00;
        tick();
        check_all("single_rel", 3'd0, 8'h00, 1'b0, 1'b0);      // ptr = 6

        // Simultaneous requests with ptr = 6: 6, then 0, then 1.
        bus.req = 8'h43;
        tick();
        check_all("simul_6", 3'd6, 8'h40, 1'b1, 1'b1);
        bus.req = 8'h03;
        tick();
        check_all("simul_0", 3'd0, 8'h01, 1'b1, 1'b1);         // ptr = 7
        bus.req = 8'h02;
        tick();
        check_all("simul_1", 3'd1, 8'h02, 1'b1, 1'b1);         // ptr = 1
        bus.req = 8'h00;
        tick();
        check_all("simul_idle", 3'd0, 8'h00, 1'b0, 1'b0);      // ptr = 2

        // Rotation and wrap between requesters 7 and 0, no idle gap.
        bus.req = 8'h81;
        tick();
        check_all("wrap_7a", 3'd7, 8'h80, 1'b1, 1'b1);
        bus.req = 8'h01;
        tick();
        check_all("wrap_0a", 3'd0, 8'h01, 1'b1, 1'b1);         // ptr wraps to 0
        bus.req = 8'h80;
        tick();
        check_all("wrap_7b", 3'd7, 8'h80, 1'b1, 1'b1);
        bus.req = 8'h01;
        tick();
        check_all("wrap_0b", 3'd0, 8'h01, 1'b1, 1'b1);
        bus.req = 8'h00;
        tick();
        check_all("wrap_idle", 3'd0, 8'h00, 1'b0, 1'b0);       // ptr = 1

        // Requester 2 drops before being served; requester 0 arrives on the release edge.
        bus.req = 8'h06;
        tick();
        check_all("drop_1", 3'd1, 8'h02, 1'b1, 1'b1);
        bus.req = 8'h01;
        tick();
        check_all("drop_0", 3'd0, 8'h01, 1'b1, 1'b1);
        bus.req = 8'h00;
        tick();
        check_all("drop_idle", 3'd0, 8'h00, 1'b0, 1'b0);       // ptr = 1

        // Two requesters held constant for 300 cycles; ptr = 1 so requester 1 wins first.
        bus.req = 8'h03;
        for (int i = 0; i < 300; i++) begin
            tick();
`ifdef HOLD_LIMIT_EN
            e_sel   = ((i / 4) % 2 == 0) ? 3'd1 : 3'd0;
            e_chg   = (i % 4 == 0);
`else
            e_sel   = 3'd1;
            e_chg   = (i == 0);
`endif
            e_grant = 8'h01 << e_sel;
            check_all("hold", e_sel, e_grant, 1'b1, e_chg);
        end

        // Asynchronous reset mid-grant clears outputs without a clock edge.
        sys_rst = 1'b1;
        #1;
        check_all("async_rst", 3'd0, 8'h00, 1'b0, 1'b0);
        tick();
        sys_rst = 1'b0;
        tick();
        check_all("restart", 3'd0, 8'h01, 1'b1, 1'b1);         // ptr restarted at 0
        bus.req = 8'h00;
        tick();
        check_all("final_idle", 3'd0, 8'h00, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
